// File: rtl/ucsbece154_mem_pkg.sv
// Shared definitions for the two-port SDRAM read arbiter.
package ucsbece154_mem_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Words per SDRAM burst unless the top is overridden.
  localparam int BLOCK_WORDS_DEFAULT = 4;

  // Requester indices as seen on Grant.
  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/ucsbece154_rr_picker.sv
// Two-way round-robin select: a lone requester wins outright, and on a tie
// the requester that was not served last wins.
module ucsbece154_rr_picker
  import ucsbece154_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic       o_valid,
  output logic       o_sel
);

  // Pick the owner from the current request vector and last-served index.
  always_comb begin
    o_valid = |i_req;
    o_sel   = REQ_ICACHE;
    if (i_req == 2'b11) begin
      o_sel = ~i_rr_last;
    end else if (i_req[1]) begin
      o_sel = REQ_DCACHE;
    end
  end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Shares the SDRAM-controller read port between the icache (port 0) and the
// dcache refill path (port 1). One block burst per grant, round-robin order.
//
// state | meaning
// IDLE  | waiting for a request; owner and address are latched on exit
// ISSUE | one cycle; raises MemReadRequest for the owner
// XFER  | counting MemDataReady beats, routing them to the owner
// GAP   | one-cycle turnaround with MemReadRequest low before re-arbitrating
module ucsbece154_mem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
  parameter int NUM_REQ     = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Req0,
  input  logic [31:0]                Addr0,
  input  logic                       Req1,
  input  logic [31:0]                Addr1,
  output logic [31:0]                Data0,
  output logic                       DataReady0,
  output logic                       Done0,
  output logic [31:0]                Data1,
  output logic                       DataReady1,
  output logic                       Done1,
  output logic [$clog2(NUM_REQ)-1:0] Grant,
  output logic                       Busy,
  output logic [31:0]                MemReadAddress,
  output logic                       MemReadRequest,
  input  logic [31:0]                MemDataIn,
  input  logic                       MemDataReady
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [$clog2(NUM_REQ)-1:0] r_grant;
  logic [31:0]                r_addr;
  logic                       r_mem_req;
  logic                       r_busy;
  logic                       r_done0;
  logic                       r_done1;
  logic                       r_rr_last;
  logic [CNT_W-1:0]           r_word_cnt;

  logic w_pick_valid;
  logic w_pick_sel;
  logic w_load;
  logic w_beat;
  logic w_last;

  ucsbece154_rr_picker u_picker (
    .i_req     ({Req1, Req0}),
    .i_rr_last (r_rr_last),
    .o_valid   (w_pick_valid),
    .o_sel     (w_pick_sel)
  );

  // Beats only count while a burst is being transferred; strays are dropped.
  assign w_beat = MemDataReady && (r_state == XFER);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the load/last strobes for the datapath.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_load       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = XFER;
      XFER: begin
        if (w_beat && (r_word_cnt == LAST_WORD)) begin
          w_last       = 1'b1;
          w_state_next = GAP;
        end
      end
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Grant/address latch, request line, beat counter, done pulses, rr history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_grant    <= '0;
      r_addr     <= '0;
      r_mem_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_word_cnt <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_load) begin
        r_grant <= w_pick_sel;
        r_addr  <= w_pick_sel ? Addr1 : Addr0;
        r_busy  <= 1'b1;
      end
      if (r_state == ISSUE) begin
        r_mem_req <= 1'b1;
      end
      if (w_beat) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_mem_req  <= 1'b0;
        r_done0    <= (r_grant == REQ_ICACHE);
        r_done1    <= (r_grant == REQ_DCACHE);
        r_rr_last  <= r_grant;
        r_word_cnt <= '0;
      end
      if (r_state == GAP) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign Data0          = MemDataIn;
  assign Data1          = MemDataIn;
  assign DataReady0     = w_beat && (r_grant == REQ_ICACHE);
  assign DataReady1     = w_beat && (r_grant == REQ_DCACHE);
  assign Done0          = r_done0;
  assign Done1          = r_done1;
  assign Grant          = r_grant;
  assign Busy           = r_busy;
  assign MemReadAddress = r_addr;
  assign MemReadRequest = r_mem_req;

endmodule
